// File: rtl/vic_sched.sv
// Priority scheduler and CPU handshake controller for the VICtor interrupt controller.
// Picks the highest-priority unmasked pending source, raises a level request with its vector,
// and keeps a stack of in-service priorities so only strictly higher priorities can preempt.
module vic_sched #(
  parameter int unsigned NSRC   = 31,
  parameter int unsigned PRIO_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [NSRC-1:0]          i_pend,
  input  logic [NSRC-1:0]          i_mask,
  input  logic [NSRC*PRIO_W-1:0]   i_prio,
  input  logic                     i_ack,
  input  logic                     i_eoi,
  output logic                     o_IRQ,
  output logic [4:0]               o_irq_addr,
  output logic [NSRC-1:0]          o_clr,
  output logic [2:0]               o_depth,
  output logic                     o_err
);

  localparam int unsigned VecW = 5;
  localparam int unsigned DepW = 3;
  localparam logic [NSRC-1:0] ClrOne = {{(NSRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StReq, StSettle} state_e;

  state_e              state_q, state_d;
  logic [VecW-1:0]     vec_q, vec_d;
  logic [PRIO_W-1:0]   prio_q, prio_d;
  logic [NSRC-1:0]     clr_q, clr_d;
  logic [DepW-1:0]     depth_q, depth_d;
  logic                err_q, err_d;
  // Only priorities are stacked: nothing downstream consumes the in-service vectors.
  logic [PRIO_W-1:0]   stk_q [DEPTH];
  logic [PRIO_W-1:0]   stk_d [DEPTH];

  logic                win_found;
  logic [VecW-1:0]     win_vec;
  logic [PRIO_W-1:0]   win_prio;
  logic [PRIO_W-1:0]   top_prio;
  logic                win_valid;
  logic                full;
  logic                withdraw;
  logic [DepW-1:0]     depth_pop;
  logic                push;

  // Winner search: strict '>' keeps the lowest index on priority ties.
  always_comb begin
    win_found = 1'b0;
    win_vec   = '0;
    win_prio  = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      if (i_pend[s] && !i_mask[s] &&
          (!win_found || i_prio[s*PRIO_W +: PRIO_W] > win_prio)) begin
        win_found = 1'b1;
        win_vec   = VecW'(s);
        win_prio  = i_prio[s*PRIO_W +: PRIO_W];
      end
    end
  end

  // Priority of the current top-of-stack entry (don't care when empty).
  always_comb begin
    top_prio = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (DepW'(i + 1) == depth_q) top_prio = stk_q[i];
    end
  end

  assign win_valid = win_found && ((depth_q == '0) || (win_prio > top_prio));
  assign full      = (depth_q == DepW'(DEPTH));
  assign withdraw  = !i_en || !i_pend[vec_q] || i_mask[vec_q];

  // Next-state: handshake FSM plus stack update (pop applied before push).
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    prio_d    = prio_q;
    clr_d     = '0;
    err_d     = err_q;
    stk_d     = stk_q;
    depth_pop = depth_q;
    push      = 1'b0;

    if (i_eoi) begin
      if (depth_q != '0) depth_pop = depth_q - 1'b1;
      else               err_d     = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_en && win_valid && !full) begin
          vec_d   = win_vec;
          prio_d  = win_prio;
          state_d = StReq;
        end
      end
      StReq: begin
        // Ack beats a same-cycle withdraw condition.
        if (i_ack) begin
          push    = 1'b1;
          clr_d   = ClrOne << vec_q;
          state_d = StSettle;
        end else if (withdraw) begin
          state_d = StIdle;
        end
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    depth_d = depth_pop;
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (DepW'(i) == depth_pop) stk_d[i] = prio_q;
      end
      depth_d = depth_pop + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      prio_q  <= '0;
      clr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) stk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      prio_q  <= prio_d;
      clr_q   <= clr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(DEPTH); i++) stk_q[i] <= stk_d[i];
    end
  end

  assign o_IRQ      = (state_q == StReq);
  assign o_irq_addr = vec_q;
  assign o_clr      = clr_q;
  assign o_depth    = depth_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_vic_sched.sv
// Directed bench for vic_sched: a queue-based behavioural model is checked every cycle,
// and directed scenarios pin hand-computed values at key points.
module tb_vic_sched;

  localparam int NSRC = 31;
  localparam int PW   = 2;
  localparam int DEP  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [NSRC-1:0]   pend = '0;
  logic [NSRC-1:0]   mask = '0;
  logic [NSRC*PW-1:0] prio = '0;
  logic              ack = 1'b0;
  logic              eoi = 1'b0;
  logic              irq;
  logic [4:0]        addr;
  logic [NSRC-1:0]   clr;
  logic [2:0]        depth;
  logic              err;
  logic [NSRC-1:0]   clr_prev = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vic_sched #(.NSRC(NSRC), .PRIO_W(PW), .DEPTH(DEP)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_pend(pend), .i_mask(mask), .i_prio(prio),
    .i_ack(ack), .i_eoi(eoi), .o_IRQ(irq), .o_irq_addr(addr), .o_clr(clr),
    .o_depth(depth), .o_err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prio_of(input int s);
    return int'(prio[s*PW +: PW]);
  endfunction

  // ---------------- behavioural model ----------------
  int unsigned     stk[$];
  bit              m_req = 1'b0;
  bit              m_gap = 1'b0;
  bit              m_err = 1'b0;
  int              m_vec = 0;
  int              m_prio = 0;
  logic [NSRC-1:0] m_clr = '0;
  int              best, bp, sz0;
  bit              ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk.delete();
      m_req = 1'b0; m_gap = 1'b0; m_err = 1'b0; m_vec = 0; m_prio = 0; m_clr = '0;
    end else begin
      best = -1; bp = -1;
      for (int s = 0; s < NSRC; s++)
        if (pend[s] && !mask[s] && prio_of(s) > bp) begin best = s; bp = prio_of(s); end
      sz0 = stk.size();
      ok = (best >= 0) && (sz0 == 0 || bp > int'(stk[sz0-1]));
      m_clr = '0;
      if (eoi) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_err = 1'b1;
      end
      if (m_req) begin
        if (ack) begin
          stk.push_back(m_prio);
          m_clr[m_vec] = 1'b1;
          m_req = 1'b0;
          m_gap = 1'b1;
        end else if (!en || !pend[m_vec] || mask[m_vec]) begin
          m_req = 1'b0;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (en && ok && sz0 < DEP) begin
        m_req = 1'b1; m_vec = best; m_prio = bp;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_irq", 32'(irq), 32'(m_req));
    if (m_req) chk("m_addr", 32'(addr), 32'(m_vec));
    chk("m_clr", 32'(clr), 32'(m_clr));
    chk("m_depth", 32'(depth), 32'(stk.size()));
    chk("m_err", 32'(err), 32'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  // Advance one edge; the pending flag cleared by o_clr drops on the edge after the pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    pend = pend & ~clr_prev;
    clr_prev = clr;
  endtask

  task automatic set_src(input int s, input int p);
    prio[s*PW +: PW] = PW'(p);
    pend[s] = 1'b1;
  endtask

  // Ack the outstanding request, EOI during the settle cycle.
  task automatic serve();
    ack = 1'b1; tick(); ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic launch_ack(input int s, input int p, input int d_after);
    set_src(s, p);
    tick();
    chk("nest_irq", 32'(irq), 32'd1);
    chk("nest_addr", 32'(addr), 32'(s));
    ack = 1'b1; tick(); ack = 1'b0;
    chk("nest_depth", 32'(depth), 32'(d_after));
    tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;

    // Basic handshake
    set_src(7, 1);
    tick();
    chk("basic_irq", 32'(irq), 32'd1);
    chk("basic_addr", 32'(addr), 32'd7);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("basic_clr", 32'(clr), 32'h80);
    chk("basic_depth", 32'(depth), 32'd1);
    chk("basic_irq_low", 32'(irq), 32'd0);
    tick();
    chk("basic_clr_once", 32'(clr), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("basic_eoi_depth", 32'(depth), 32'd0);

    // Priority and tie-break
    set_src(3, 2); set_src(9, 2); set_src(1, 1);
    tick();
    chk("prio_first", 32'(addr), 32'd3);
    serve(); tick();
    chk("prio_second", 32'(addr), 32'd9);
    serve(); tick();
    chk("prio_third", 32'(addr), 32'd1);
    serve();

    // Nesting
    launch_ack(5, 1, 1);
    set_src(12, 1);
    tick(); tick();
    chk("nest_no12", 32'(irq), 32'd0);
    set_src(20, 3);
    tick();
    chk("nest_20", 32'(addr), 32'd20);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("nest_depth2", 32'(depth), 32'd2);
    tick(); tick();
    chk("nest_still_no12", 32'(irq), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("nest_eoi1_no12", 32'(irq), 32'd0);
    chk("nest_eoi1_depth", 32'(depth), 32'd1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("nest_eoi2_depth", 32'(depth), 32'd0);
    chk("nest_eoi2_irq", 32'(irq), 32'd0);
    tick();
    chk("nest_12_irq", 32'(irq), 32'd1);
    chk("nest_12_addr", 32'(addr), 32'd12);
    serve();

    // Withdraw on mask
    set_src(4, 0);
    tick();
    chk("wd_req", 32'(irq), 32'd1);
    mask[4] = 1'b1;
    tick();
    chk("wd_irq", 32'(irq), 32'd0);
    chk("wd_clr", 32'(clr), 32'd0);
    chk("wd_depth", 32'(depth), 32'd0);
    mask[4] = 1'b0;
    tick();
    chk("wd_rereq", 32'(addr), 32'd4);
    serve();

    // Simultaneous ack and EOI: new top must be the acked priority
    launch_ack(21, 0, 1);
    set_src(22, 2);
    tick();
    chk("ae_addr", 32'(addr), 32'd22);
    ack = 1'b1; eoi = 1'b1; tick(); ack = 1'b0; eoi = 1'b0;
    chk("ae_depth", 32'(depth), 32'd1);
    chk("ae_clr", 32'(clr), 32'h0040_0000);
    tick();
    set_src(23, 1);
    tick(); tick();
    chk("ae_top_is_acked", 32'(irq), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("ae_23", 32'(addr), 32'd23);
    serve();

    // Full stack then underflow
    for (int k = 0; k < DEP; k++) launch_ack(10 + k, k, k + 1);
    set_src(14, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_no_irq", 32'(irq), 32'd0);
    end
    mask[14] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      eoi = 1'b1; tick(); eoi = 1'b0;
      chk("uf_err", 32'(err), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("uf_depth", 32'(depth), 32'd0);

    // Async reset while a request is outstanding
    launch_ack(17, 0, 1);
    mask[14] = 1'b0;
    tick();
    chk("ar_req", 32'(addr), 32'd14);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_irq", 32'(irq), 32'd0);
    chk("ar_depth", 32'(depth), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_addr", 32'(addr), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after_irq", 32'(irq), 32'd1);
    chk("ar_after_addr", 32'(addr), 32'd14);
    pend = '0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
